// File: rtl/maxpool_2x2_1_pkg.sv
// Shared constants and types for the 2x2 stride-2 max-pool block.
// Default geometry is 24x24 samples of 12 bits, pooled to 12x12.
package maxpool_2x2_1_pkg;

    localparam int DEF_WIDTH    = 24;
    localparam int DEF_HEIGHT   = 24;
    localparam int DEF_DATA_BIT = 12;
    localparam int POOL_W       = DEF_WIDTH / 2;
    localparam int POOL_H       = DEF_HEIGHT / 2;

    // Per-beat commands the shared controller broadcasts to every channel lane.
    typedef struct packed {
        logic hold_pair;   // even column: capture the left sample of a pair
        logic write_line;  // even row, odd column: park the horizontal max
        logic emit;        // odd row, odd column: register the pooled result
    } lane_ctrl_t;

    // Index width for a counter or memory of the given depth, never below 1 bit.
    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/maxpool_2x2_1_lane.sv
// One channel of the max-pool datapath: pair register, half-width line buffer,
// signed comparators and the output register. Macro MAXPOOL_RELU_EN clamps results at 0.
module maxpool_lane
    import maxpool_2x2_1_pkg::*;
#(
    parameter int DATA_BIT   = DEF_DATA_BIT,
    parameter int LINE_DEPTH = POOL_W,
    parameter int AW         = addr_bits(LINE_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  lane_ctrl_t                 ctrl,
    input  logic [AW-1:0]              line_addr,
    input  logic signed [DATA_BIT-1:0] sample,
    output logic signed [DATA_BIT-1:0] max_out
);

    logic signed [DATA_BIT-1:0] pair_q;
    logic signed [DATA_BIT-1:0] h_max;
    logic signed [DATA_BIT-1:0] pool_max;
    logic signed [DATA_BIT-1:0] result;
    logic signed [DATA_BIT-1:0] line_buf [LINE_DEPTH];

    always_comb begin
        h_max    = (pair_q > sample) ? pair_q : sample;
        pool_max = (line_buf[line_addr] > h_max) ? line_buf[line_addr] : h_max;
`ifdef MAXPOOL_RELU_EN
        result   = pool_max[DATA_BIT-1] ? '0 : pool_max;
`else
        result   = pool_max;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pair_q  <= '0;
            max_out <= '0;
        end else begin
            if (ctrl.hold_pair) pair_q  <= sample;
            if (ctrl.emit)      max_out <= result;
        end
    end

    // NOTE: the line buffer is deliberately left out of reset; each entry is
    // written on an even row before the following odd row reads it.
    always_ff @(posedge clk) begin
        if (ctrl.write_line) line_buf[line_addr] <= h_max;
    end

endmodule

// File: rtl/maxpool_2x2_1.sv
// 2x2 stride-2 max pooling over three channels in raster order.
// Shared column/row control drives three maxpool_lane instances; macro MAXPOOL_RELU_EN enables ReLU.
module maxpool_2x2_1
    import maxpool_2x2_1_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int HEIGHT   = DEF_HEIGHT,
    parameter int DATA_BIT = DEF_DATA_BIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic [DATA_BIT-1:0] conv_in_1,
    input  logic [DATA_BIT-1:0] conv_in_2,
    input  logic [DATA_BIT-1:0] conv_in_3,
    output logic [DATA_BIT-1:0] max_out_1,
    output logic [DATA_BIT-1:0] max_out_2,
    output logic [DATA_BIT-1:0] max_out_3,
    output logic                valid_out,
    output logic                frame_done
);

    localparam int CW         = addr_bits(WIDTH);
    localparam int RW         = addr_bits(HEIGHT);
    localparam int LINE_DEPTH = WIDTH / 2;
    localparam int AW         = addr_bits(LINE_DEPTH);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          accept;
    logic          col_last;
    logic          row_last;
    logic [AW-1:0] line_addr;
    lane_ctrl_t    ctrl;

    // Reset wins over a coincident beat, so nothing reaches the lanes while rst is high.
    assign accept    = valid_in & ~rst;
    assign col_last  = (col == CW'(WIDTH - 1));
    assign row_last  = (row == RW'(HEIGHT - 1));
    assign line_addr = AW'(col >> 1);

    // NOTE: defaulting every output of the block first keeps the conditional
    // assignments below from inferring latches.
    always_comb begin
        ctrl = '0;
        if (accept) begin
            ctrl.hold_pair  = ~col[0];
            ctrl.write_line =  col[0] & ~row[0];
            ctrl.emit       =  col[0] &  row[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= ctrl.emit;
            frame_done <= ctrl.emit & col_last & row_last;
            if (accept) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    maxpool_lane #(.DATA_BIT(DATA_BIT), .LINE_DEPTH(LINE_DEPTH), .AW(AW)) u_lane_1 (
        .clk       (clk),
        .rst       (rst),
        .ctrl      (ctrl),
        .line_addr (line_addr),
        .sample    (conv_in_1),
        .max_out   (max_out_1)
    );

    maxpool_lane #(.DATA_BIT(DATA_BIT), .LINE_DEPTH(LINE_DEPTH), .AW(AW)) u_lane_2 (
        .clk       (clk),
        .rst       (rst),
        .ctrl      (ctrl),
        .line_addr (line_addr),
        .sample    (conv_in_2),
        .max_out   (max_out_2)
    );

    maxpool_lane #(.DATA_BIT(DATA_BIT), .LINE_DEPTH(LINE_DEPTH), .AW(AW)) u_lane_3 (
        .clk       (clk),
        .rst       (rst),
        .ctrl      (ctrl),
        .line_addr (line_addr),
        .sample    (conv_in_3),
        .max_out   (max_out_3)
    );

endmodule
